// File: rtl/converter_f2i_param.sv
// IEEE-754 single to OUT_W-bit signed integer converter with stb/ack handshakes,
// truncate / round-to-nearest-even, saturation and {invalid, overflow, inexact} flags.
module converter_f2i_param #(
  parameter int OUT_W = 32
) (
  input  logic             i_CLK,
  input  logic             i_RSTN,
  input  logic [31:0]      i_A,
  input  logic             i_A_STB,
  output logic             o_A_ACK,
  input  logic             i_RND_MODE,
  output logic [OUT_W-1:0] o_Z,
  output logic [2:0]       o_Z_FLG,
  output logic             o_Z_STB,
  input  logic             i_Z_ACK
);

  typedef enum logic [2:0] {GET_A, UNPACK, ALIGN, ROUND, PACK, PUT_Z} state_t;

  localparam logic [32:0]      LIM_N = 33'd1 << (OUT_W - 1);
  localparam logic [32:0]      LIM_P = LIM_N - 33'd1;
  localparam logic [OUT_W-1:0] ZMAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] ZMIN  = {1'b1, {(OUT_W-1){1'b0}}};

  state_t             state_q;
  logic               a_ack_q, z_stb_q;
  logic [OUT_W-1:0]   z_q;
  logic [2:0]         flg_q;
  logic [31:0]        a_q;
  logic               rnd_q, s_q, zero_q, inv_q;
  logic signed [8:0]  e_q;
  logic [23:0]        m_q;
  logic [32:0]        int_q, mag_q;
  logic               grd_q, stk_q, big_q, inx_q, ovf_q, pk_ph_q;

  logic [32:0]        int_d;
  logic               grd_d, stk_d, big_d;
  logic [5:0]         e_u;
  logic [47:0]        wide_d;
  logic [OUT_W-1:0]   mag_w;
  logic [OUT_W-1:0]   z_d;
  logic [2:0]         flg_d;

  assign o_A_ACK = a_ack_q;
  assign o_Z_STB = z_stb_q;
  assign o_Z     = z_q;
  assign o_Z_FLG = flg_q;

  // Alignment: integer part, guard (first dropped bit) and sticky (OR of the rest).
  // Exponents above 31 cannot fit any legal OUT_W, so they only raise big_d.
  always_comb begin
    int_d  = '0;
    grd_d  = 1'b0;
    stk_d  = 1'b0;
    big_d  = 1'b0;
    wide_d = '0;
    e_u    = e_q[5:0];
    if (zero_q) begin
      stk_d = |m_q[22:0];
    end else if (e_q < 9'sd0) begin
      grd_d = (e_q == -9'sd1);
      stk_d = (e_q == -9'sd1) ? |m_q[22:0] : 1'b1;
    end else if (e_q > 9'sd31) begin
      big_d = 1'b1;
    end else if (e_q >= 9'sd23) begin
      int_d = {9'b0, m_q} << (e_u - 6'd23);
    end else begin
      wide_d = {m_q, 24'b0} >> (6'd23 - e_u);
      int_d  = {9'b0, wide_d[47:24]};
      grd_d  = wide_d[23];
      stk_d  = |wide_d[22:0];
    end
  end

  always_comb begin
    mag_w = mag_q[OUT_W-1:0];
    z_d   = '0;
    flg_d = 3'b000;
    if (inv_q) begin
      flg_d = 3'b100;
    end else if (ovf_q) begin
      z_d   = s_q ? ZMIN : ZMAX;
      flg_d = 3'b010;
    end else begin
      z_d   = s_q ? -mag_w : mag_w;
      flg_d = {2'b00, inx_q};
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTN) begin
      state_q <= GET_A;
      a_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
      z_q     <= '0;
      flg_q   <= '0;
      a_q     <= '0;
      rnd_q   <= 1'b0;
      s_q     <= 1'b0;
      e_q     <= '0;
      m_q     <= '0;
      zero_q  <= 1'b0;
      inv_q   <= 1'b0;
      int_q   <= '0;
      grd_q   <= 1'b0;
      stk_q   <= 1'b0;
      big_q   <= 1'b0;
      mag_q   <= '0;
      inx_q   <= 1'b0;
      ovf_q   <= 1'b0;
      pk_ph_q <= 1'b0;
    end else begin
      case (state_q)
        GET_A: begin
          if (a_ack_q && i_A_STB) begin
            a_q     <= i_A;
            rnd_q   <= i_RND_MODE;
            a_ack_q <= 1'b0;
            state_q <= UNPACK;
          end else begin
            a_ack_q <= 1'b1;
          end
        end
        UNPACK: begin
          s_q     <= a_q[31];
          e_q     <= $signed({1'b0, a_q[30:23]}) - 9'sd127;
          m_q     <= {1'b1, a_q[22:0]};
          zero_q  <= (a_q[30:23] == 8'h00);
          inv_q   <= (a_q[30:23] == 8'hFF);
          state_q <= ALIGN;
        end
        ALIGN: begin
          int_q   <= int_d;
          grd_q   <= grd_d;
          stk_q   <= stk_d;
          big_q   <= big_d;
          state_q <= ROUND;
        end
        ROUND: begin
          mag_q   <= int_q + {32'b0, rnd_q & grd_q & (stk_q | int_q[0])};
          inx_q   <= grd_q | stk_q;
          state_q <= PACK;
        end
        PACK: begin
          // Two phases: range compare first, then negate/saturate into the output regs.
          if (!pk_ph_q) begin
            ovf_q   <= big_q | (s_q ? (mag_q > LIM_N) : (mag_q > LIM_P));
            pk_ph_q <= 1'b1;
          end else begin
            pk_ph_q <= 1'b0;
            z_q     <= z_d;
            flg_q   <= flg_d;
            z_stb_q <= 1'b1;
            state_q <= PUT_Z;
          end
        end
        PUT_Z: begin
          if (i_Z_ACK) begin
            z_stb_q <= 1'b0;
            a_ack_q <= 1'b1;
            state_q <= GET_A;
          end
        end
        default: state_q <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_converter_f2i_param.sv
// Randomized + directed bench for converter_f2i_param at OUT_W=32 and OUT_W=16,
// checked against a remainder-based float-to-int reference model.
module tb_converter_f2i_param;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] a = '0;
  logic        a_stb = 1'b0, rnd = 1'b0, z_ack = 1'b0;
  logic        a_ack32, z_stb32, a_ack16, z_stb16;
  logic [31:0] z32;
  logic [15:0] z16;
  logic [2:0]  f32, f16;

  int nchk = 0, nerr = 0;
  int cyc = 0;
  int last_tx = 0;
  bit prev_pre = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  converter_f2i_param #(.OUT_W(32)) u32 (
    .i_CLK(clk), .i_RSTN(rstn), .i_A(a), .i_A_STB(a_stb), .o_A_ACK(a_ack32),
    .i_RND_MODE(rnd), .o_Z(z32), .o_Z_FLG(f32), .o_Z_STB(z_stb32), .i_Z_ACK(z_ack)
  );

  converter_f2i_param #(.OUT_W(16)) u16 (
    .i_CLK(clk), .i_RSTN(rstn), .i_A(a), .i_A_STB(a_stb), .o_A_ACK(a_ack16),
    .i_RND_MODE(rnd), .o_Z(z16), .o_Z_FLG(f16), .o_Z_STB(z_stb16), .i_Z_ACK(z_ack)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {flags, z}; value = m * 2^(exp-150), rounded via integer remainder vs half.
  function automatic logic [34:0] f2i_model(input logic [31:0] av, input bit rv, input int w);
    int               ex, sh, r;
    bit               s, inx, ovf, up;
    longint unsigned  m, mg, lim, den, ip, rem, z, mask;
    ex  = int'(av[30:23]);
    s   = av[31];
    m   = {40'd0, 1'b1, av[22:0]};
    lim = 64'd1 << (w - 1);
    mask = (64'd1 << w) - 64'd1;
    inx = 1'b0;
    ovf = 1'b0;
    mg  = 0;
    if (ex == 255) return {3'b100, 32'd0};
    if (ex == 0)   return {2'b00, (av[22:0] != 0), 32'd0};
    sh = ex - 150;
    if (sh >= 0) begin
      if (sh >= 40) ovf = 1'b1;
      else mg = m << sh;
    end else begin
      r = -sh;
      if (r >= 40) begin
        mg  = 0;
        inx = 1'b1;
      end else begin
        den = 64'd1 << r;
        ip  = m / den;
        rem = m % den;
        inx = (rem != 0);
        up  = rv && ((2 * rem > den) || ((2 * rem == den) && (ip % 2 == 1)));
        mg  = ip + (up ? 64'd1 : 64'd0);
      end
    end
    if (!ovf) ovf = s ? (mg > lim) : (mg > lim - 1);
    if (ovf) begin
      z = s ? (64'd0 - lim) : (lim - 1);
      z = z & mask;
      return {3'b010, z[31:0]};
    end
    z = s ? (64'd0 - mg) : mg;
    z = z & mask;
    return {2'b00, inx, z[31:0]};
  endfunction

  task automatic op(input logic [31:0] av, input logic rv, input int hold, input bit pre_ack,
                    output logic [31:0] oz32, output logic [2:0] of32);
    int n, tx;
    logic [34:0] e32, e16;
    n = 0;
    while (!a_ack32 && n < 40) begin @(negedge clk); n++; end
    chk("a_ack_wait", a_ack32, 1);
    a = av; rnd = rv; a_stb = 1'b1; z_ack = pre_ack;
    @(negedge clk);
    tx = cyc;
    a_stb = 1'b0; a = $urandom; rnd = 1'($urandom);
    if (pre_ack && prev_pre) chk("period", tx - last_tx, 7);
    last_tx = tx;
    prev_pre = pre_ack;
    n = 0;
    while (!z_stb32 && n < 20) begin @(negedge clk); n++; end
    chk("latency", n, 5);
    e32 = f2i_model(av, rv, 32);
    e16 = f2i_model(av, rv, 16);
    chk("z32", z32, e32[31:0]);
    chk("f32", f32, e32[34:32]);
    chk("z16", z16, e16[15:0]);
    chk("f16", f16, e16[34:32]);
    chk("stb16", z_stb16, 1);
    oz32 = z32; of32 = f32;
    if (!pre_ack) begin
      for (int i = 0; i < hold; i++) begin
        a_stb = 1'b1; a = $urandom;
        @(negedge clk);
        chk("hold_z", z32, oz32);
        chk("hold_stb", z_stb32, 1);
        chk("hold_aack", a_ack32, 0);
      end
      a_stb = 1'b0; z_ack = 1'b1;
    end
    @(negedge clk);
    chk("done_stb", z_stb32, 0);
    chk("done_aack", a_ack32, 1);
    z_ack = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        r;
    bit          w16;
    logic [31:0] z;
    logic [2:0]  f;
    int          hold;
  } dcase_t;

  dcase_t dc[14];

  initial begin
    logic [31:0] rz;
    logic [2:0]  rf;
    logic [31:0] av;
    int          seen;

    dc = '{
      '{32'h40200000, 1'b0, 1'b0, 32'h00000002, 3'b001, 6},
      '{32'h40200000, 1'b1, 1'b0, 32'h00000002, 3'b001, 0},
      '{32'h40600000, 1'b1, 1'b0, 32'h00000004, 3'b001, 1},
      '{32'hBFC00000, 1'b0, 1'b0, 32'hFFFFFFFF, 3'b001, 0},
      '{32'hBFC00000, 1'b1, 1'b0, 32'hFFFFFFFE, 3'b001, 0},
      '{32'h471C4000, 1'b0, 1'b1, 32'h00007FFF, 3'b010, 0},
      '{32'hC7000000, 1'b0, 1'b1, 32'h00008000, 3'b000, 0},
      '{32'h46FFFFE0, 1'b1, 1'b1, 32'h00007FFF, 3'b010, 0},
      '{32'h7FC00000, 1'b0, 1'b0, 32'h00000000, 3'b100, 0},
      '{32'hFF800000, 1'b1, 1'b0, 32'h00000000, 3'b100, 0},
      '{32'h00000001, 1'b0, 1'b0, 32'h00000000, 3'b001, 0},
      '{32'h80000000, 1'b1, 1'b0, 32'h00000000, 3'b000, 0},
      '{32'h3F000000, 1'b1, 1'b0, 32'h00000000, 3'b001, 0},
      '{32'h3F000001, 1'b1, 1'b0, 32'h00000001, 3'b001, 0}
    };

    repeat (3) @(negedge clk);
    chk("rst_aack", a_ack32, 0);
    chk("rst_stb", z_stb32, 0);
    chk("rst_z", z32, 0);
    chk("rst_flg", f32, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_aack", a_ack32, 1);

    foreach (dc[i]) begin
      op(dc[i].a, dc[i].r, dc[i].hold, 1'b0, rz, rf);
      if (dc[i].w16) begin
        chk("dir_z16", {16'd0, z16}, dc[i].z);
        chk("dir_f16", f16, dc[i].f);
      end else begin
        chk("dir_z32", rz, dc[i].z);
        chk("dir_f32", rf, dc[i].f);
      end
    end

    // Reset while the 10.0 operand sits in ALIGN.
    a = 32'h41200000; rnd = 1'b0; a_stb = 1'b1;
    @(negedge clk);
    a_stb = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_aack", a_ack32, 0);
    chk("mid_rst_stb", z_stb32, 0);
    chk("mid_rst_z", z32, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rel_aack", a_ack32, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (z_stb32) seen++;
    end
    chk("mid_no_stb", seen, 0);
    prev_pre = 1'b0;
    op(32'h42F60000, 1'b0, 0, 1'b0, rz, rf);
    chk("after_rst_z", rz, 32'd123);
    chk("after_rst_f", rf, 3'b000);

    for (int i = 0; i < 150; i++) begin
      av = $urandom;
      case ($urandom_range(0, 9))
        0:       av[30:23] = 8'hFF;
        1:       av[30:23] = 8'h00;
        2:       av[30:23] = 8'(142 + $urandom_range(0, 20));
        default: av[30:23] = 8'($urandom_range(110, 160));
      endcase
      op(av, 1'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)), rz, rf);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
